// File: rtl/fwd_hazard_ctrl_if.sv
// Forwarding/hazard controller bus: ID-stage decode fields in, selects and stall out.
// master = pipeline side (drives ID fields), slave = controller.
interface fwd_hazard_ctrl_if #(
  parameter int RegAddrWidth = 5,
  parameter int FwSelWidth   = 2
);
  logic                    stall_ext;
  logic                    flush_ID;
  logic [RegAddrWidth-1:0] rs_ID;
  logic [RegAddrWidth-1:0] rt_ID;
  logic                    use_rs_ID;
  logic                    use_rt_ID;
  logic                    use_hi_ID;
  logic                    use_lo_ID;
  logic [RegAddrWidth-1:0] target_ID;
  logic                    we_reg_ID;
  logic                    mem_read_ID;
  logic                    we_hi_ID;
  logic                    we_lo_ID;
  logic [FwSelWidth-1:0]   FWA;
  logic [FwSelWidth-1:0]   FWB;
  logic [FwSelWidth-1:0]   FWhi;
  logic [FwSelWidth-1:0]   FWlo;
  logic                    stall_ID;
  logic                    bubble_EX;

  modport master (
    output stall_ext, flush_ID, rs_ID, rt_ID,
    output use_rs_ID, use_rt_ID, use_hi_ID, use_lo_ID,
    output target_ID, we_reg_ID, mem_read_ID,
    output we_hi_ID, we_lo_ID,
    input  FWA, FWB, FWhi, FWlo, stall_ID, bubble_EX
  );

  modport slave (
    input  stall_ext, flush_ID, rs_ID, rt_ID,
    input  use_rs_ID, use_rt_ID, use_hi_ID, use_lo_ID,
    input  target_ID, we_reg_ID, mem_read_ID,
    input  we_hi_ID, we_lo_ID,
    output FWA, FWB, FWhi, FWlo, stall_ID, bubble_EX
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Shadows EX/MEM occupants; registers GPR/HI/LO forward selects; load-use stall.
// Ports: clk, rst (sync, active-high), bus (slave modport of fwd_hazard_ctrl_if).
module fwd_hazard_ctrl #(
  parameter int RegAddrWidth = 5,
  parameter int FwSelWidth   = 2
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_ctrl_if.slave bus
);
  localparam logic [FwSelWidth-1:0] SelRf  = FwSelWidth'(0);
  localparam logic [FwSelWidth-1:0] SelMem = FwSelWidth'(1);
  localparam logic [FwSelWidth-1:0] SelWb  = FwSelWidth'(2);

  logic                    ex_valid;
  logic [RegAddrWidth-1:0] ex_target;
  logic                    ex_we_reg;
  logic                    ex_mem_read;
  logic                    ex_we_hi;
  logic                    ex_we_lo;

  logic                    mem_valid;
  logic [RegAddrWidth-1:0] mem_target;
  logic                    mem_we_reg;
  logic                    mem_we_hi;
  logic                    mem_we_lo;

  logic ex_gpr, mem_gpr;
  logic a_ex, a_mem, b_ex, b_mem;
  logic hi_ex, hi_mem, lo_ex, lo_mem;
  logic stall, bubble;

  // Nearer producer wins.
  function automatic logic [FwSelWidth-1:0] pick(
    input logic near,
    input logic far
  );
    if (near) return SelMem;
    if (far) return SelWb;
    return SelRf;
  endfunction

  always_comb begin
    ex_gpr  = ex_valid & ex_we_reg & (ex_target != '0);
    mem_gpr = mem_valid & mem_we_reg & (mem_target != '0);
    a_ex    = ex_gpr & bus.use_rs_ID & (bus.rs_ID == ex_target);
    a_mem   = mem_gpr & bus.use_rs_ID & (bus.rs_ID == mem_target);
    b_ex    = ex_gpr & bus.use_rt_ID & (bus.rt_ID == ex_target);
    b_mem   = mem_gpr & bus.use_rt_ID & (bus.rt_ID == mem_target);
    hi_ex   = ex_valid & ex_we_hi & bus.use_hi_ID;
    hi_mem  = mem_valid & mem_we_hi & bus.use_hi_ID;
    lo_ex   = ex_valid & ex_we_lo & bus.use_lo_ID;
    lo_mem  = mem_valid & mem_we_lo & bus.use_lo_ID;
    // A load in EX cannot feed ID's consumer via MEM forward yet.
    stall   = ex_mem_read & (a_ex | b_ex);
    bubble  = stall | bus.flush_ID;
  end

  assign bus.stall_ID  = stall;
  assign bus.bubble_EX = bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_target   <= '0;
      ex_we_reg   <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_we_hi    <= 1'b0;
      ex_we_lo    <= 1'b0;
      mem_valid   <= 1'b0;
      mem_target  <= '0;
      mem_we_reg  <= 1'b0;
      mem_we_hi   <= 1'b0;
      mem_we_lo   <= 1'b0;
      bus.FWA     <= SelRf;
      bus.FWB     <= SelRf;
      bus.FWhi    <= SelRf;
      bus.FWlo    <= SelRf;
    end else if (!bus.stall_ext) begin
      mem_valid  <= ex_valid;
      mem_target <= ex_target;
      mem_we_reg <= ex_we_reg;
      mem_we_hi  <= ex_we_hi;
      mem_we_lo  <= ex_we_lo;
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_target   <= '0;
        ex_we_reg   <= 1'b0;
        ex_mem_read <= 1'b0;
        ex_we_hi    <= 1'b0;
        ex_we_lo    <= 1'b0;
        bus.FWA     <= SelRf;
        bus.FWB     <= SelRf;
        bus.FWhi    <= SelRf;
        bus.FWlo    <= SelRf;
      end else begin
        ex_valid    <= 1'b1;
        ex_target   <= bus.target_ID;
        ex_we_reg   <= bus.we_reg_ID;
        ex_mem_read <= bus.mem_read_ID;
        ex_we_hi    <= bus.we_hi_ID;
        ex_we_lo    <= bus.we_lo_ID;
        bus.FWA     <= pick(a_ex, a_mem);
        bus.FWB     <= pick(b_ex, b_mem);
        bus.FWhi    <= pick(hi_ex, hi_mem);
        bus.FWlo    <= pick(lo_ex, lo_mem);
      end
    end
  end
endmodule
